// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a framed image (16-bit word count, big-endian
// payload words, XOR checksum), writes instruction memory and releases the CPU once verified.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int COUNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic        byte_ready_out,
  output logic        imem_write_out,
  output logic [31:0] imem_address_out,
  output logic [31:0] imem_data_out,
  output logic        cpu_hold_out,
  output logic        done_out,
  output logic        error_out,
  output logic [2:0]  state_out
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR_HI  = 3'd1;
  localparam logic [2:0] HDR_LO  = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  // Byte handshake: a byte moves on any clock edge where byte_valid_in and
  // byte_ready_out are both 1; ready depends only on state, never on valid.
  logic [2:0]         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] index_q, index_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [23:0]        shift_q, shift_d;
  logic [7:0]         csum_q, csum_d;
  logic               wr_q, wr_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [COUNT_W-1:0] cnt_full;
  logic               accept;

  assign byte_ready_out   = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                            (state_q == PAYLOAD) || (state_q == CHECK);
  assign accept           = byte_valid_in && byte_ready_out;
  assign imem_write_out   = wr_q;
  assign imem_address_out = addr_q;
  assign imem_data_out    = data_q;
  assign cpu_hold_out     = (state_q != DONE);
  assign done_out         = (state_q == DONE);
  assign error_out        = (state_q == ERROR);
  assign state_out        = state_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    csum_d   = csum_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_full = COUNT_W'({count_q[7:0], byte_in});

    // The index advances in the strobe cycle, which may already be a CHECK cycle.
    if (wr_q) index_d = index_q + COUNT_W'(1);

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_in) begin
          state_d = HDR_HI;
          index_d = '0;
          csum_d  = '0;
          bcnt_d  = '0;
          count_d = '0;
        end
      end
      HDR_HI: begin
        if (accept) begin
          count_d = COUNT_W'(byte_in);
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (accept) begin
          count_d = cnt_full;
          if (cnt_full > COUNT_W'(DEPTH_WORDS)) state_d = ERROR;
          else if (cnt_full == '0)              state_d = CHECK;
          else                                  state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shift_d = {shift_q[15:0], byte_in};
          csum_d  = csum_q ^ byte_in;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_d   = 1'b1;
            data_d = {shift_q, byte_in};
            addr_d = 32'({index_q, 2'b00});
            if (index_q == count_q - COUNT_W'(1)) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) state_d = (byte_in == csum_q) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      csum_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      csum_q  <= csum_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with hand-computed writes/checksums,
// header limits, gapped streams, ignored starts and asynchronous reset mid-frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_in = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid_in = 1'b0;
  logic        byte_ready_out;
  logic        imem_write_out;
  logic [31:0] imem_address_out;
  logic [31:0] imem_data_out;
  logic        cpu_hold_out;
  logic        done_out;
  logic        error_out;
  logic [2:0]  state_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words_q[$];

  imem_loader dut (
    .clk              (clk),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .byte_in          (byte_in),
    .byte_valid_in    (byte_valid_in),
    .byte_ready_out   (byte_ready_out),
    .imem_write_out   (imem_write_out),
    .imem_address_out (imem_address_out),
    .imem_data_out    (imem_data_out),
    .cpu_hold_out     (cpu_hold_out),
    .done_out         (done_out),
    .error_out        (error_out),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (!reset_in && imem_write_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", imem_address_out, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", imem_address_out, e[63:32]);
        check("wr_data", imem_data_out, e[31:0]);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    byte_in = b;
    byte_valid_in = 1'b1;
    while (!byte_ready_out && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!byte_ready_out) check("ready_timeout", 32'd0, 32'd1);
    else @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  // Sends header, words_q payload and checksum^flip; optionally gapped, with a start
  // pulse riding on payload byte 5 when mid_start is set.
  task automatic run_frame(input logic [7:0] flip, input bit gaps, input bit mid_start);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    int          k;
    cs = 8'h00;
    k = 0;
    n = 16'(words_q.size());
    pulse_start();
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      exp_q.push_back({32'(i * 4), w});
      for (int j = 3; j >= 0; j--) begin
        logic [7:0] b;
        b = w[j*8 +: 8];
        cs = cs ^ b;
        if (mid_start && k == 5) start_in = 1'b1;
        send_byte(b);
        start_in = 1'b0;
        if (gaps && (k % 2 == 0)) idle(1 + $urandom_range(0, 2));
        k++;
      end
    end
    send_byte(cs ^ flip);
    byte_valid_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, 32'(byte_ready_out), 32'd0);
    check({pfx, "_wr"},    32'(imem_write_out), 32'd0);
    check({pfx, "_addr"},  imem_address_out, 32'd0);
    check({pfx, "_data"},  imem_data_out, 32'd0);
    check({pfx, "_hold"},  32'(cpu_hold_out), 32'd1);
    check({pfx, "_done"},  32'(done_out), 32'd0);
    check({pfx, "_err"},   32'(error_out), 32'd0);
  endtask

  task automatic check_end(input string pfx, input bit ok);
    check({pfx, "_done"},    32'(done_out), ok ? 32'd1 : 32'd0);
    check({pfx, "_err"},     32'(error_out), ok ? 32'd0 : 32'd1);
    check({pfx, "_hold"},    32'(cpu_hold_out), ok ? 32'd0 : 32'd1);
    check({pfx, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_in = 1'b0;
    @(negedge clk);
    check("idle_hold", 32'(cpu_hold_out), 32'd1);

    // Gap-free good frame, checksum 0x55.
    words_q = '{32'h2002_0005, 32'h0042_1020};
    run_frame(8'h00, 1'b0, 1'b0);
    check_end("good", 1'b1);

    // Restart from DONE: hold reasserts and done clears once start registers.
    pulse_start();
    check("restart_hold", 32'(cpu_hold_out), 32'd1);
    check("restart_done", 32'(done_out), 32'd0);
    check("restart_ready", 32'(byte_ready_out), 32'd1);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);

    // Same frame, checksum 0x54: writes still happen, frame rejected.
    run_frame(8'h01, 1'b0, 1'b0);
    check_end("badcs", 1'b0);

    // Header 257 exceeds depth.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    byte_valid_in = 1'b1;
    byte_in = 8'hAA;
    check("hdr257_err", 32'(error_out), 32'd1);
    check("hdr257_ready", 32'(byte_ready_out), 32'd0);
    idle(8);
    check("hdr257_nowr", 32'(exp_q.size()), 32'd0);

    // Empty image.
    words_q.delete();
    run_frame(8'h00, 1'b0, 1'b0);
    check_end("empty_ok", 1'b1);
    run_frame(8'h01, 1'b0, 1'b0);
    check_end("empty_bad", 1'b0);

    // Gapped stream with an ignored mid-payload start.
    words_q = '{32'h2002_0005, 32'h0042_1020};
    run_frame(8'h00, 1'b1, 1'b1);
    check_end("gaps", 1'b1);

    // Exactly DEPTH_WORDS words is accepted.
    words_q.delete();
    for (int i = 0; i < 256; i++) words_q.push_back(32'h1357_9BDF ^ (32'(i) * 32'h0101_0103));
    run_frame(8'h00, 1'b0, 1'b0);
    check_end("full", 1'b1);

    // Asynchronous reset after 6 payload bytes.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({32'h0, 32'h2002_0005});
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h42);
    byte_valid_in = 1'b0;
    #2 reset_in = 1'b1;
    #1 check_reset_outputs("async");
    check("async_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    words_q = '{32'h2002_0005, 32'h0042_1020};
    run_frame(8'h00, 1'b0, 1'b0);
    check_end("after_rst", 1'b1);

    idle(4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    check("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
